fpu_issue_ctrl: RTL

// Issue sequencer directly upstream of pfpu32_top. Buffers FPU commands in a small FIFO.

---
 rtl/fpu_issue_ctrl_if.sv | 37 +++
 rtl/fpu_issue_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Command / response handshake bundle between a core-side
// issuer and fpu_issue_ctrl.
interface fpu_issue_ctrl_if #(
   parameter int TAG_W   = 4,
   parameter int FPCSR_W = 12
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [7:0]         cmd_op;
   logic [31:0]        cmd_a;
   logic [31:0]        cmd_b;
   logic [1:0]         cmd_rm;
   logic [TAG_W-1:0]   cmd_tag;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_result;
   logic               rsp_cmp;
   logic [FPCSR_W-1:0] rsp_fpcsr;
   logic [TAG_W-1:0]   rsp_tag;
   logic               rsp_tmo;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid, rsp_result, rsp_cmp, rsp_fpcsr,
      input  rsp_tag, rsp_tmo
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid, rsp_result, rsp_cmp, rsp_fpcsr,
      output rsp_tag, rsp_tmo
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer in front of pfpu32_top: command FIFO,
// decode/execute strobes, result capture and timeout flush.
module fpu_issue_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int FPCSR_W = 12,
   parameter int TMO     = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   fpu_issue_ctrl_if.slave    bus,
   output logic               flush_o,
   output logic               padv_decode_o,
   output logic               padv_execute_o,
   output logic [7:0]         op_fpu_o,
   output logic [31:0]        rfa_o,
   output logic [31:0]        rfb_o,
   output logic [1:0]         round_mode_o,
   input  logic [31:0]        fpu_result_i,
   input  logic               arith_valid_i,
   input  logic               cmp_flag_i,
   input  logic               cmp_valid_i,
   input  logic [FPCSR_W-1:0] fpcsr_i
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TMO);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   typedef struct packed {
      logic [7:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [1:0]       rm;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t               mem [DEPTH];
   cmd_t               head;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [2:0]         state;
   logic [TW-1:0]      timer;
   logic               push;
   logic               pop;
   logic               exp_valid;
   logic [TAG_W-1:0]   tag_q;
   logic [31:0]        res_q;
   logic               cmp_q;
   logic [FPCSR_W-1:0] csr_q;
   logic               tmo_q;

   assign bus.cmd_ready  = count < CW'(DEPTH);
   assign push           = bus.cmd_valid && bus.cmd_ready;
   assign pop            = (state == S_IDLE) && (count != '0);
   assign head           = mem[rd_ptr];
   assign exp_valid      = op_fpu_o[3] ? cmp_valid_i
                                       : arith_valid_i;
   assign bus.rsp_valid  = state == S_RESP;
   assign bus.rsp_result = res_q;
   assign bus.rsp_cmp    = cmp_q;
   assign bus.rsp_fpcsr  = csr_q;
   assign bus.rsp_tag    = tag_q;
   assign bus.rsp_tmo    = tmo_q;

   // Storage needs no reset: count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b,
                         bus.cmd_rm, bus.cmd_tag};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         timer          <= '0;
         flush_o        <= 1'b0;
         padv_decode_o  <= 1'b0;
         padv_execute_o <= 1'b0;
         op_fpu_o       <= '0;
         rfa_o          <= '0;
         rfb_o          <= '0;
         round_mode_o   <= '0;
         tag_q          <= '0;
         res_q          <= '0;
         cmp_q          <= 1'b0;
         csr_q          <= '0;
         tmo_q          <= 1'b0;
      end else begin
         flush_o        <= 1'b0;
         padv_decode_o  <= 1'b0;
         padv_execute_o <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  op_fpu_o      <= head.op;
                  rfa_o         <= head.a;
                  rfb_o         <= head.b;
                  round_mode_o  <= head.rm;
                  tag_q         <= head.tag;
                  padv_decode_o <= 1'b1;
                  state         <= S_DECODE;
               end
            end
            S_DECODE: begin
               padv_execute_o <= 1'b1;
               state          <= S_EXEC;
            end
            S_EXEC: begin
               timer <= '0;
               state <= S_WAIT;
            end
            // A valid on the last counted cycle beats the flush.
            S_WAIT: begin
               if (exp_valid) begin
                  res_q <= op_fpu_o[3] ? 32'd0 : fpu_result_i;
                  cmp_q <= op_fpu_o[3] & cmp_flag_i;
                  csr_q <= fpcsr_i;
                  tmo_q <= 1'b0;
                  state <= S_RESP;
               end else if (timer == TW'(TMO - 1)) begin
                  flush_o <= 1'b1;
                  state   <= S_FLUSH;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_FLUSH: begin
               res_q <= '0;
               cmp_q <= 1'b0;
               csr_q <= '0;
               tmo_q <= 1'b1;
               state <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
